// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared constants for the RTC phase sequencer and the bus drivers that
// consume its phase code.
//   - Phase codes PH_IDLE..PH_READ_TIMER (3-bit codes on the `state` bus)
//   - STATE_W     : width of the phase code
//   - fsm_e       : sequencer FSM encoding (ARMED / RUN / GAP)
//   - edge_mode_e : which transition an edge_det instance reports
//   - select_phase: arbitration of pending requests into one phase per frame
// -----------------------------------------------------------------------------
package rtc_pkg;

   localparam int STATE_W = 3;

   localparam logic [2:0] PH_IDLE        = 3'd0;
   localparam logic [2:0] PH_INIT_STATUS = 3'd1;
   localparam logic [2:0] PH_INIT_CONFIG = 3'd2;
   localparam logic [2:0] PH_READ_TIME   = 3'd3;
   localparam logic [2:0] PH_READ_DATE   = 3'd4;
   localparam logic [2:0] PH_WRITE_TIME  = 3'd5;
   localparam logic [2:0] PH_FORMAT      = 3'd6;
   localparam logic [2:0] PH_READ_TIMER  = 3'd7;

   typedef enum logic [1:0] {
      ARMED = 2'd0,
      RUN   = 2'd1,
      GAP   = 2'd2
   } fsm_e;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_mode_e;

   // Fixed-priority choice of the phase to run in the coming frame.
   // With nothing pending the sequencer alternates time and date reads.
   function automatic logic [2:0] select_phase(
      input logic init_pending,
      input logic write_pending,
      input logic fmt_pending,
      input logic timer_en,
      input logic date_toggle
   );
      logic [2:0] code;
      if (init_pending)       code = PH_INIT_STATUS;
      else if (write_pending) code = PH_WRITE_TIME;
      else if (fmt_pending)   code = PH_FORMAT;
      else if (timer_en)      code = PH_READ_TIMER;
      else if (date_toggle)   code = PH_READ_DATE;
      else                    code = PH_READ_TIME;
      return code;
   endfunction

endpackage

// File: rtl/rtc_phase_sequencer_edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// One-bit registered transition detector. The register holds the previous
// sample of `sig`; `pulse` compares it against the current level.
//   clk   in  system clock
//   sig   in  level to watch
//   pulse out high for one cycle on the transition selected by MODE
// The register reloads `sig` on every edge, reset included, so after reset
// it always matches the input and no false edge can be reported.
// -----------------------------------------------------------------------------
module edge_det
   import rtc_pkg::*;
#(
   parameter edge_mode_e MODE = EDGE_ANY
) (
   input  logic clk,
   input  logic sig,
   output logic pulse
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = sig;
   end

   // NOTE: clocked state is written with <= so every flop samples the
   // pre-edge values of its neighbours, independent of block ordering.
   always_ff @(posedge clk) begin
      sig_q <= sig_d;
   end

   always_comb begin
      pulse = 1'b0;
      unique case (MODE)
         EDGE_RISE: pulse = sig & ~sig_q;
         EDGE_FALL: pulse = ~sig & sig_q;
         default:   pulse = sig ^ sig_q;
      endcase
   end

endmodule

// File: rtl/rtc_phase_sequencer.sv
// -----------------------------------------------------------------------------
// rtc_phase_sequencer
// Master sequencer for the RTC parallel-bus drivers. On each falling edge of
// v_sync it picks one pending job and holds its phase code on `state` for
// PHASE_LEN cycles, then idles for GAP_LEN cycles. The power-up init chain
// (INIT_STATUS then INIT_CONFIG) runs back-to-back without waiting a frame.
//   clk           in  system clock
//   reset         in  synchronous, active-high reset
//   v_sync        in  frame sync level; high during RUN aborts the phase
//   sw_formato    in  12/24-hour switch; any change requests a FORMAT phase
//   control_timer in  timer-mode select; any change requests a FORMAT phase
//   timer_en      in  enables periodic timer-register reads
//   write_req     in  one-cycle request for a time write
//   state         out active phase code (0 when idle)
//   busy          out high in RUN and GAP
//   done          out one-cycle pulse on the last cycle of a completed phase
//   done_state    out code of the completing phase, valid with done
// -----------------------------------------------------------------------------
module rtc_phase_sequencer
   import rtc_pkg::*;
#(
   parameter int PHASE_LEN = 42,
   parameter int GAP_LEN   = 4,
   parameter int STATE_W   = rtc_pkg::STATE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               v_sync,
   input  logic               sw_formato,
   input  logic               control_timer,
   input  logic               timer_en,
   input  logic               write_req,
   output logic [STATE_W-1:0] state,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] done_state
);

   localparam int CNT_W = $clog2(PHASE_LEN > GAP_LEN ? PHASE_LEN : GAP_LEN);
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(PHASE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

   logic vs_fall;
   logic sw_chg;
   logic ct_chg;

   edge_det #(.MODE(EDGE_FALL)) u_vs_edge (.clk(clk), .sig(v_sync),        .pulse(vs_fall));
   edge_det #(.MODE(EDGE_ANY))  u_sw_edge (.clk(clk), .sig(sw_formato),    .pulse(sw_chg));
   edge_det #(.MODE(EDGE_ANY))  u_ct_edge (.clk(clk), .sig(control_timer), .pulse(ct_chg));

   fsm_e               fsm_q,          fsm_d;
   logic [CNT_W-1:0]   cnt_q,          cnt_d;
   logic [STATE_W-1:0] code_q,         code_d;
   logic               init_pending_q, init_pending_d;
   logic               chain_q,        chain_d;       // INIT_CONFIG follows the gap
   logic               write_pending_q, write_pending_d;
   logic               fmt_pending_q,  fmt_pending_d;
   logic               date_toggle_q,  date_toggle_d;
   logic               phase_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q           <= ARMED;
         cnt_q           <= '0;
         code_q          <= '0;
         init_pending_q  <= 1'b1;
         chain_q         <= 1'b0;
         write_pending_q <= 1'b0;
         fmt_pending_q   <= 1'b1;
         date_toggle_q   <= 1'b0;
      end else begin
         fsm_q           <= fsm_d;
         cnt_q           <= cnt_d;
         code_q          <= code_d;
         init_pending_q  <= init_pending_d;
         chain_q         <= chain_d;
         write_pending_q <= write_pending_d;
         fmt_pending_q   <= fmt_pending_d;
         date_toggle_q   <= date_toggle_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      fsm_d           = fsm_q;
      cnt_d           = cnt_q;
      code_d          = code_q;
      init_pending_d  = init_pending_q;
      chain_d         = chain_q;
      write_pending_d = write_pending_q;
      fmt_pending_d   = fmt_pending_q;
      date_toggle_d   = date_toggle_q;
      phase_done      = 1'b0;

      unique case (fsm_q)
         ARMED: begin
            if (vs_fall) begin
               fsm_d  = RUN;
               cnt_d  = '0;
               code_d = STATE_W'(select_phase(init_pending_q, write_pending_q,
                                              fmt_pending_q, timer_en, date_toggle_q));
            end
         end

         RUN: begin
            if (v_sync) begin
               // Frame ran out before the drivers finished: drop the phase
               // and let the same request win again next frame.
               fsm_d   = GAP;
               cnt_d   = '0;
               chain_d = 1'b0;
            end else if (cnt_q == RUN_LAST) begin
               fsm_d      = GAP;
               cnt_d      = '0;
               phase_done = 1'b1;
               unique case (code_q)
                  STATE_W'(PH_INIT_STATUS): chain_d = 1'b1;
                  STATE_W'(PH_INIT_CONFIG): begin
                     init_pending_d = 1'b0;
                     chain_d        = 1'b0;
                  end
                  STATE_W'(PH_WRITE_TIME):  write_pending_d = 1'b0;
                  STATE_W'(PH_FORMAT):      fmt_pending_d   = 1'b0;
                  STATE_W'(PH_READ_TIME),
                  STATE_W'(PH_READ_DATE):   date_toggle_d   = ~date_toggle_q;
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (chain_q) begin
                  fsm_d  = RUN;
                  code_d = STATE_W'(PH_INIT_CONFIG);
               end else begin
                  fsm_d = ARMED;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: fsm_d = ARMED;
      endcase

      // New requests are applied after the completion clears so that a
      // request arriving on the final cycle re-queues the phase.
      if (write_req)       write_pending_d = 1'b1;
      if (sw_chg | ct_chg) fmt_pending_d   = 1'b1;
   end

   assign state      = (fsm_q == RUN) ? code_q : '0;
   assign busy       = (fsm_q != ARMED);
   assign done       = phase_done;
   assign done_state = phase_done ? code_q : '0;

endmodule

// File: tb/tb_rtc_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rtc_phase_sequencer
// Drives frames of v_sync with directed and random side requests and checks
// every cycle against a countdown-based reference of the frame scheduler.
// -----------------------------------------------------------------------------
module tb_rtc_phase_sequencer;

   localparam int PHASE_LEN = 42;
   localparam int GAP_LEN   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       v_sync = 1'b1;
   logic       sw_formato = 1'b0;
   logic       control_timer = 1'b0;
   logic       timer_en = 1'b0;
   logic       write_req = 1'b0;
   logic [2:0] state;
   logic       busy;
   logic       done;
   logic [2:0] done_state;

   int checks = 0;
   int errors = 0;

   // reference model: cycles left in the running phase / gap
   int m_run_code, m_run_left, m_gap_left;
   bit m_chain, m_ip, m_wp, m_fp, m_tog;
   bit m_pv, m_psw, m_pct;

   // per-frame observations
   int f_seen, f_ndone;

   always #5 clk = ~clk;

   rtc_phase_sequencer #(.PHASE_LEN(PHASE_LEN), .GAP_LEN(GAP_LEN), .STATE_W(3)) dut (
      .clk(clk), .reset(reset), .v_sync(v_sync), .sw_formato(sw_formato),
      .control_timer(control_timer), .timer_en(timer_en), .write_req(write_req),
      .state(state), .busy(busy), .done(done), .done_state(done_state)
   );

   function automatic int pick_code();
      if (m_ip) return 1;
      if (m_wp) return 5;
      if (m_fp) return 6;
      if (timer_en) return 7;
      return m_tog ? 4 : 3;
   endfunction

   // Advance the reference by one clock edge using the inputs sampled there.
   task automatic model_edge();
      if (reset) begin
         m_run_code = 0; m_run_left = 0; m_gap_left = 0;
         m_chain = 0; m_ip = 1; m_wp = 0; m_fp = 1; m_tog = 0;
      end else begin
         if (m_run_left > 0) begin
            if (v_sync) begin
               m_run_left = 0; m_gap_left = GAP_LEN; m_chain = 0;
            end else if (m_run_left == 1) begin
               m_run_left = 0; m_gap_left = GAP_LEN;
               case (m_run_code)
                  1: m_chain = 1;
                  2: m_ip = 0;
                  5: m_wp = 0;
                  6: m_fp = 0;
                  3, 4: m_tog = !m_tog;
                  default: ;
               endcase
            end else begin
               m_run_left--;
            end
         end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0 && m_chain) begin
               m_chain = 0; m_run_code = 2; m_run_left = PHASE_LEN;
            end
         end else if (m_pv && !v_sync) begin
            m_run_code = pick_code(); m_run_left = PHASE_LEN;
         end
         if (write_req) m_wp = 1;
         if (sw_formato != m_psw || control_timer != m_pct) m_fp = 1;
      end
      m_pv = v_sync; m_psw = sw_formato; m_pct = control_timer;
   endtask

   task automatic check_outputs();
      logic [2:0] e_state, e_ds;
      logic       e_busy, e_done;
      e_state = (m_run_left > 0) ? 3'(m_run_code) : 3'd0;
      e_busy  = (m_run_left > 0) || (m_gap_left > 0);
      e_done  = (m_run_left == 1) && !v_sync;
      e_ds    = e_done ? 3'(m_run_code) : 3'd0;
      checks++;
      assert (state === e_state) else begin
         errors++; $error("FAIL state obs=%0d exp=%0d t=%0t", state, e_state, $time);
      end
      checks++;
      assert (busy === e_busy) else begin
         errors++; $error("FAIL busy obs=%0b exp=%0b t=%0t", busy, e_busy, $time);
      end
      checks++;
      assert (done === e_done) else begin
         errors++; $error("FAIL done obs=%0b exp=%0b t=%0t", done, e_done, $time);
      end
      checks++;
      assert (done_state === e_ds) else begin
         errors++; $error("FAIL done_state obs=%0d exp=%0d t=%0t", done_state, e_ds, $time);
      end
   endtask

   task automatic step();
      #1;
      check_outputs();
      if (f_seen == 0 && state != 3'd0) f_seen = int'(state);
      if (done === 1'b1) f_ndone++;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // One frame: v_sync high for hi cycles then low for lo cycles. Side
   // events fire at the given frame index (-1 disables).
   task automatic run_frame(input int hi, input int lo, input int wr_at,
                            input int sw_at, input int ct_at, input int rst_at);
      f_seen = 0; f_ndone = 0;
      for (int i = 0; i < hi + lo; i++) begin
         v_sync    = (i < hi);
         write_req = (i == wr_at);
         if (i == sw_at) sw_formato    = ~sw_formato;
         if (i == ct_at) control_timer = ~control_timer;
         reset = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
         step();
      end
      write_req = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input int exp_code, input int exp_done);
      checks++;
      assert (f_seen === exp_code) else begin
         errors++; $error("FAIL %s code obs=%0d exp=%0d", tag, f_seen, exp_code);
      end
      checks++;
      assert (f_ndone === exp_done) else begin
         errors++; $error("FAIL %s done_count obs=%0d exp=%0d", tag, f_ndone, exp_done);
      end
   endtask

   initial begin
      int hi, lo, wr, sw, ct;

      // reset held with v_sync high
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         model_edge();
      end
      #1;
      reset = 1'b0;

      // init chain back-to-back, then forced FORMAT, then 3/4 alternation
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("init", 1, 2);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("fmt_after_init", 6, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("read_a", 3, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("read_b", 4, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("read_c", 3, 1);

      // write request and format switch in the same frame
      run_frame(10, 100, 60, 70, -1, -1); expect_frame("req_frame", 4, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("write", 5, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("format", 6, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("resume", 3, 1);

      // write aborted by v_sync at phase cycle 20, retried next frame
      run_frame(10, 100, 60, -1, -1, -1); expect_frame("pre_abort", 4, 1);
      run_frame(10, 21, -1, -1, -1, -1);  expect_frame("abort", 5, 0);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("retry", 5, 1);

      // control_timer toggles on the last cycle of FORMAT: repeats
      run_frame(10, 100, -1, 70, -1, -1); expect_frame("pre_fmt", 3, 1);
      run_frame(10, 100, -1, -1, 52, -1); expect_frame("fmt_last", 6, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("fmt_again", 6, 1);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("read_d", 4, 1);

      // reset at cycle 15 of READ_TIME, then init restarts
      run_frame(10, 100, -1, -1, -1, 26); expect_frame("reset_mid", 3, 0);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("reinit", 1, 2);
      run_frame(10, 100, -1, -1, -1, -1); expect_frame("fmt_reinit", 6, 1);

      // random frames: short frames abort, requests land anywhere
      for (int f = 0; f < 25; f++) begin
         hi = int'($urandom_range(2, 15));
         lo = int'($urandom_range(20, 110));
         wr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, hi + lo - 1)) : -1;
         sw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, hi + lo - 1)) : -1;
         ct = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, hi + lo - 1)) : -1;
         timer_en = 1'($urandom_range(0, 1));
         run_frame(hi, lo, wr, sw, ct, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_phase_sequencer.md
Name: rtc_phase_sequencer

Overview:
Upstream master sequencer for the RTC parallel-bus drivers: it generates the 3-bit `state` code that selects which bus-driver stage (init, read time/date, write, format, timer read) may run. The drivers reset their internal cycle counters on `v_sync`, so each phase starts on the falling edge of `v_sync`. Each phase is held for a fixed cycle window, and pending requests are arbitrated one phase per frame. The power-up init chain is the only exception and runs back-to-back.

Parameters:
PHASE_LEN, 42, cycles `state` is held non-zero per phase; must exceed the longest driver window (0..40).
GAP_LEN, 4, cycles of `state`=0 after each phase before the sequencer re-arms.
STATE_W, 3, width of the phase code.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
v_sync  in  1  frame sync level from the VGA timing block
sw_formato  in  1  12/24-hour format switch
control_timer  in  1  timer-mode select
timer_en  in  1  enables periodic timer-register reads
write_req  in  1  one-cycle pulse from the user edit logic requesting a time write
state  out  STATE_W  active phase code consumed by the bus drivers
busy  out  1  high while `state`≠0 or during the gap
done  out  1  one-cycle pulse on phase completion
done_state  out  STATE_W  code of the phase that just completed; valid with `done`

Behaviour:
- Phase codes (shared constants): 0 IDLE, 1 INIT_STATUS, 2 INIT_CONFIG, 3 READ_TIME, 4 READ_DATE, 5 WRITE_TIME, 6 FORMAT, 7 READ_TIMER.
- Reset values:
  - Outputs: `state`=0, `busy`=0, `done`=0, `done_state`=0.
  - Internal: init_pending=1, write_pending=0, fmt_pending=1 (forces one FORMAT after init), date_toggle=0, phase counter=0.
  - Edge registers load current `v_sync`, `sw_formato` and `control_timer` so that no false edge occurs.
- FSM states: ARMED, RUN, GAP.
- ARMED:
  - Waits for the registered falling edge of `v_sync`; the decision is made on the cycle after the edge is seen.
  - `state` is driven in that same cycle (latency 1 clk from the edge detect).
  - Priority: init_pending → 1; write_pending → 5; fmt_pending → 6; timer_en → 7; else 3 if date_toggle=0, 4 if date_toggle=1.
  - date_toggle flips each time a 3/4 phase completes.
- RUN:
  - `state` is held for exactly PHASE_LEN cycles while the counter counts 0..PHASE_LEN-1.
  - On the last cycle: `done`=1, `done_state`=code, and the matching pending flag clears.
  - Then go to GAP with `state`=0.
- Init chain: completion of 1 enters RUN with code 2 directly after GAP, without waiting for `v_sync`. Completion of 2 clears init_pending.
- GAP: `state`=0 for GAP_LEN cycles, then ARMED; `busy` stays high throughout GAP.
- Abort:
  - If `v_sync`=1 during RUN, the next cycle forces `state`=0 and enters GAP.
  - `done` is not pulsed and the pending flag is not cleared, so the phase retries next frame.
  - The init chain restarts at 1.
- Request latching:
  - write_pending sets on `write_req`=1 in any state.
  - fmt_pending sets when `sw_formato` or `control_timer` differs from its registered copy.
  - If a set and a clear hit the same cycle, set wins, so the phase repeats.
- `v_sync` falling edge seen during RUN/GAP: ignored; no queuing of frames.
- Reset asserted mid-phase: next cycle `state`=0 and all reset values reload.

Decomposition:
- Package rtc_pkg: phase-code localparams (PH_IDLE..PH_READ_TIMER), STATE_W, and the FSM encodings ARMED/RUN/GAP.
- Sub-module edge_det (registered rise/fall/change detect, 1 bit) instantiated for `v_sync`, `sw_formato` and `control_timer`.

Test Plan:
- Reset, then `v_sync` high 10 cycles then low → `state`=1 for 42 cycles, 0 for 4, `state`=2 for 42; `done` pulses with `done_state`=1 and then 2.
- After init, next `v_sync` fall → `state`=6 (forced FORMAT); following frames alternate 3, 4, 3 with timer_en=0.
- `write_req` pulse and a `sw_formato` toggle in the same frame → next frame `state`=5, frame after `state`=6, then 3/4 resume.
- `v_sync` rises at phase cycle 20 of code 5 → `state`=0 next cycle, no `done`; next frame re-issues 5 and completes.
- `control_timer` toggles during the final cycle of a FORMAT phase → `done` with `done_state`=6, fmt_pending stays 1, next frame runs 6 again.
- Reset asserted at cycle 15 of READ_TIME → `state`=0 next cycle; after release, first `v_sync` fall restarts the init chain at 1.
